// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared timekeeping types, limits and wrap arithmetic
package clock_pkg;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_EDIT_TH = 3'd1,
    ST_EDIT_TM = 3'd2,
    ST_EDIT_AH = 3'd3,
    ST_EDIT_AM = 3'd4,
    ST_RING    = 3'd5
  } mode_t;

  localparam logic [5:0] HOUR_MAX = 6'd23;
  localparam logic [5:0] MIN_MAX  = 6'd59;

  function automatic logic [5:0] hour_inc(input logic [5:0] h);
    return (h >= HOUR_MAX) ? 6'd0 : h + 6'd1;
  endfunction

  function automatic logic [5:0] hour_dec(input logic [5:0] h);
    return (h == 6'd0) ? HOUR_MAX : h - 6'd1;
  endfunction

  function automatic logic [5:0] min_inc(input logic [5:0] m);
    return (m >= MIN_MAX) ? 6'd0 : m + 6'd1;
  endfunction

  function automatic logic [5:0] min_dec(input logic [5:0] m);
    return (m == 6'd0) ? MIN_MAX : m - 6'd1;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - rising-edge press detector for level buttons
module btn_edge #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] btn,
  output logic [WIDTH-1:0] press
);

  logic [WIDTH-1:0] btn_q;
  logic             armed;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_q <= '0;
      armed <= 1'b0;
    end else begin
      btn_q <= btn;
      armed <= 1'b1;
    end
  end

  // The first cycle out of reset only primes history, so a held button is not a press.
  assign press = armed ? (btn & ~btn_q) : '0;

endmodule

// File: rtl/alarm_mode_ctrl.sv
// rtl/alarm_mode_ctrl.sv - button mode sequencer, time/alarm setting, alarm ring with snooze
module alarm_mode_ctrl
  import clock_pkg::*;
#(
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_alarm,
  input  logic       tick_1hz,
  input  logic [5:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic       time_load,
  output logic [5:0] load_hour,
  output logic [5:0] load_min,
  output logic [5:0] alarm_hour,
  output logic [5:0] alarm_min,
  output logic       alarm_en,
  output logic       ringing,
  output logic       snooze_act,
  output logic [2:0] mode
);

  localparam int CW = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;
  localparam logic [CW-1:0] RING_LAST = CW'(RING_SECS - 1);

  logic [3:0] press;
  logic       p_mode, p_up, p_down, p_alarm, step_up, step_dn;

  btn_edge #(.WIDTH(4)) u_btn_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   ({btn_alarm, btn_down, btn_up, btn_mode}),
    .press (press)
  );

  assign {p_alarm, p_down, p_up, p_mode} = press;
  assign step_up = p_up & ~p_down;
  assign step_dn = p_down & ~p_up;

  mode_t         state;
  logic [5:0]    edit_hour, edit_min;
  logic [5:0]    snz_hour, snz_min;
  logic [CW-1:0] ring_cnt;
  logic          match_q;

  // Snooze target: live time plus offset, carrying minutes into a wrapping hour.
  logic [6:0] snz_sum;
  logic       snz_carry;
  logic [5:0] snz_hour_n, snz_min_n;
  assign snz_sum    = {1'b0, cur_min} + 7'(SNOOZE_MIN);
  assign snz_carry  = (snz_sum >= 7'd60);
  assign snz_min_n  = snz_carry ? 6'(snz_sum - 7'd60) : snz_sum[5:0];
  assign snz_hour_n = snz_carry ? hour_inc(cur_hour) : cur_hour;

  logic [5:0] tgt_hour, tgt_min;
  logic       match, match_rise;
  assign tgt_hour   = snooze_act ? snz_hour : alarm_hour;
  assign tgt_min    = snooze_act ? snz_min  : alarm_min;
  assign match      = alarm_en && (cur_sec == 6'd0) && (cur_hour == tgt_hour) && (cur_min == tgt_min);
  assign match_rise = match & ~match_q;

  assign mode = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      time_load  <= 1'b0;
      load_hour  <= 6'd0;
      load_min   <= 6'd0;
      alarm_hour <= 6'd6;
      alarm_min  <= 6'd0;
      alarm_en   <= 1'b0;
      ringing    <= 1'b0;
      snooze_act <= 1'b0;
      edit_hour  <= 6'd0;
      edit_min   <= 6'd0;
      snz_hour   <= 6'd0;
      snz_min    <= 6'd0;
      ring_cnt   <= '0;
      match_q    <= 1'b0;
    end else begin
      time_load <= 1'b0;
      match_q   <= match;
      case (state)
        ST_RUN: begin
          if (p_alarm) begin
            alarm_en <= ~alarm_en;
            if (alarm_en) snooze_act <= 1'b0;
          end
          if (p_mode) begin
            state     <= ST_EDIT_TH;
            edit_hour <= cur_hour;
            edit_min  <= cur_min;
          end else if (match_rise) begin
            state    <= ST_RING;
            ringing  <= 1'b1;
            ring_cnt <= '0;
          end
        end
        ST_EDIT_TH: begin
          if (p_mode)       state     <= ST_EDIT_TM;
          else if (step_up) edit_hour <= hour_inc(edit_hour);
          else if (step_dn) edit_hour <= hour_dec(edit_hour);
        end
        ST_EDIT_TM: begin
          if (p_mode) begin
            state     <= ST_EDIT_AH;
            time_load <= 1'b1;
            load_hour <= edit_hour;
            load_min  <= edit_min;
          end else if (step_up) edit_min <= min_inc(edit_min);
          else if (step_dn)     edit_min <= min_dec(edit_min);
        end
        ST_EDIT_AH: begin
          if (p_mode)       state      <= ST_EDIT_AM;
          else if (step_up) alarm_hour <= hour_inc(alarm_hour);
          else if (step_dn) alarm_hour <= hour_dec(alarm_hour);
        end
        ST_EDIT_AM: begin
          if (p_mode)       state     <= ST_RUN;
          else if (step_up) alarm_min <= min_inc(alarm_min);
          else if (step_dn) alarm_min <= min_dec(alarm_min);
        end
        ST_RING: begin
          // A press in the same cycle as the final tick takes precedence over timeout.
          if (p_mode || (!p_up && tick_1hz && ring_cnt == RING_LAST)) begin
            state      <= ST_RUN;
            ringing    <= 1'b0;
            snooze_act <= 1'b0;
          end else if (p_up) begin
            state      <= ST_RUN;
            ringing    <= 1'b0;
            snooze_act <= 1'b1;
            snz_hour   <= snz_hour_n;
            snz_min    <= snz_min_n;
          end else if (tick_1hz) begin
            ring_cnt <= ring_cnt + 1'b1;
          end
        end
        default: begin
          state   <= ST_RUN;
          ringing <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_mode_ctrl.sv
// tb/tb_alarm_mode_ctrl.sv - self-checking bench for alarm_mode_ctrl
module tb_alarm_mode_ctrl;

  localparam int RS = 4;
  localparam int SM = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_alarm = 1'b0;
  logic       tick_1hz = 1'b0;
  logic [5:0] cur_hour = 6'd12, cur_min = 6'd58, cur_sec = 6'd30;
  logic       time_load, alarm_en, ringing, snooze_act;
  logic [5:0] load_hour, load_min, alarm_hour, alarm_min;
  logic [2:0] mode;

  alarm_mode_ctrl #(.RING_SECS(RS), .SNOOZE_MIN(SM)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_mode   (btn_mode),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_alarm  (btn_alarm),
    .tick_1hz   (tick_1hz),
    .cur_hour   (cur_hour),
    .cur_min    (cur_min),
    .cur_sec    (cur_sec),
    .time_load  (time_load),
    .load_hour  (load_hour),
    .load_min   (load_min),
    .alarm_hour (alarm_hour),
    .alarm_min  (alarm_min),
    .alarm_en   (alarm_en),
    .ringing    (ringing),
    .snooze_act (snooze_act),
    .mode       (mode)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: modes as small integers, times as minutes-of-day with modulo wrap.
  int       e_mode = 0, e_eh = 0, e_em = 0, e_ah = 6, e_am = 0, e_sh = 0, e_sm = 0;
  int       e_lh = 0, e_lm = 0, e_cnt = 0;
  bit       e_en = 0, e_snz = 0, e_load = 0, e_armed = 0, e_pmatch = 0;
  bit [3:0] e_pb = 4'b0;

  always @(posedge clk) begin : model
    bit pm, pu, pd, pa, up1, dn1, match, mrise;
    int t;
    if (!rst_n) begin
      e_mode <= 0; e_eh <= 0; e_em <= 0; e_ah <= 6; e_am <= 0; e_sh <= 0; e_sm <= 0;
      e_lh <= 0; e_lm <= 0; e_cnt <= 0; e_en <= 0; e_snz <= 0; e_load <= 0;
      e_armed <= 0; e_pmatch <= 0; e_pb <= 4'b0;
    end else begin
      pm  = e_armed && btn_mode  && !e_pb[0];
      pu  = e_armed && btn_up    && !e_pb[1];
      pd  = e_armed && btn_down  && !e_pb[2];
      pa  = e_armed && btn_alarm && !e_pb[3];
      up1 = pu && !pd;
      dn1 = pd && !pu;
      t = e_snz ? (e_sh * 60 + e_sm) : (e_ah * 60 + e_am);
      match = e_en && (cur_sec == 0) && ((cur_hour * 60 + cur_min) == t);
      mrise = match && !e_pmatch;
      e_armed  <= 1;
      e_pb     <= {btn_alarm, btn_down, btn_up, btn_mode};
      e_pmatch <= match;
      e_load   <= 0;
      case (e_mode)
        0: begin
          if (pa) begin e_en <= !e_en; if (e_en) e_snz <= 0; end
          if (pm) begin e_mode <= 1; e_eh <= cur_hour; e_em <= cur_min; end
          else if (mrise) begin e_mode <= 5; e_cnt <= 0; end
        end
        1: if (pm) e_mode <= 2; else if (up1) e_eh <= (e_eh + 1) % 24; else if (dn1) e_eh <= (e_eh + 23) % 24;
        2: if (pm) begin e_mode <= 3; e_load <= 1; e_lh <= e_eh; e_lm <= e_em; end
           else if (up1) e_em <= (e_em + 1) % 60; else if (dn1) e_em <= (e_em + 59) % 60;
        3: if (pm) e_mode <= 4; else if (up1) e_ah <= (e_ah + 1) % 24; else if (dn1) e_ah <= (e_ah + 23) % 24;
        4: if (pm) e_mode <= 0; else if (up1) e_am <= (e_am + 1) % 60; else if (dn1) e_am <= (e_am + 59) % 60;
        default: begin
          if (pm) begin e_mode <= 0; e_snz <= 0; end
          else if (pu) begin
            t = (cur_hour * 60 + cur_min + SM) % 1440;
            e_mode <= 0; e_snz <= 1; e_sh <= t / 60; e_sm <= t % 60;
          end else if (tick_1hz) begin
            if (e_cnt + 1 >= RS) begin e_mode <= 0; e_snz <= 0; end
            else e_cnt <= e_cnt + 1;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("mode", int'(mode), e_mode);
      chk("ringing", int'(ringing), (e_mode == 5) ? 1 : 0);
      chk("time_load", int'(time_load), int'(e_load));
      chk("load_hour", int'(load_hour), e_lh);
      chk("load_min", int'(load_min), e_lm);
      chk("alarm_hour", int'(alarm_hour), e_ah);
      chk("alarm_min", int'(alarm_min), e_am);
      chk("alarm_en", int'(alarm_en), int'(e_en));
      chk("snooze_act", int'(snooze_act), int'(e_snz));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input logic [3:0] b);
    {btn_alarm, btn_down, btn_up, btn_mode} = b;
  endtask

  task automatic press(input logic [3:0] b);
    step(1);
    set_btn(b);
    step(1);
    set_btn(4'b0);
  endtask

  task automatic tick_pulse(input logic [3:0] b);
    step(1);
    tick_1hz = 1'b1;
    set_btn(b);
    step(1);
    tick_1hz = 1'b0;
    set_btn(4'b0);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    cur_hour = 6'(h); cur_min = 6'(m); cur_sec = 6'(s);
  endtask

  initial begin
    // Reset with mode held; held button must not count as a press.
    btn_mode = 1'b1;
    step(1);
    started = 1'b1;
    step(2);
    rst_n = 1'b1;
    step(3);
    chk("lit_held_mode", int'(mode), 0);
    btn_mode = 1'b0;
    press(4'b0001);
    chk("lit_edit_th", int'(mode), 1);
    press(4'b0001);
    press(4'b0001);
    chk("lit_load_strobe", int'(time_load), 1);
    chk("lit_load_snapshot", int'(load_hour) * 100 + int'(load_min), 1258);
    step(1);
    chk("lit_load_one_cycle", int'(time_load), 0);
    press(4'b0001);
    press(4'b0001);

    // Hour/minute wrap in time edit.
    set_time(23, 59, 30);
    press(4'b0001);
    press(4'b0010);
    press(4'b0100);
    press(4'b0100);
    press(4'b0001);
    press(4'b0010);
    press(4'b0001);
    chk("lit_load_wrap", int'(load_hour) * 100 + int'(load_min), 2200);
    chk("lit_load_wrap_strobe", int'(time_load), 1);

    // Alarm set to 07:30, including up+down together and mode+up together.
    press(4'b0010);
    chk("lit_alarm_hour", int'(alarm_hour), 7);
    press(4'b0001);
    press(4'b0110);
    chk("lit_updown_nochg", int'(alarm_min), 0);
    for (int i = 0; i < 30; i++) press(4'b0100);
    chk("lit_alarm_min", int'(alarm_min), 30);
    press(4'b0011);
    chk("lit_mode_up_mode", int'(mode), 0);
    chk("lit_mode_up_min", int'(alarm_min), 30);
    press(4'b1000);
    chk("lit_alarm_en", int'(alarm_en), 1);

    // Match and dismiss; holding the matching time must not retrigger.
    set_time(7, 30, 0);
    step(1);
    chk("lit_ring_rise", int'(ringing), 1);
    press(4'b0001);
    chk("lit_dismiss", int'(ringing), 0);
    step(3);
    chk("lit_no_retrigger", int'(ringing) * 10 + int'(mode), 0);

    // Snooze across midnight.
    set_time(7, 29, 59);
    step(1);
    set_time(7, 30, 0);
    step(1);
    chk("lit_ring_again", int'(mode), 5);
    set_time(23, 58, 10);
    press(4'b0010);
    chk("lit_snooze_act", int'(snooze_act), 1);
    set_time(0, 3, 0);
    step(1);
    chk("lit_snooze_ring", int'(ringing), 1);
    press(4'b0001);
    chk("lit_snooze_clear", int'(snooze_act), 0);

    // Auto-dismiss after RS ticks.
    set_time(7, 29, 0);
    step(1);
    set_time(7, 30, 0);
    step(1);
    set_time(7, 30, 1);
    for (int i = 0; i < RS - 1; i++) tick_pulse(4'b0);
    chk("lit_ring_before_timeout", int'(ringing), 1);
    tick_pulse(4'b0);
    chk("lit_timeout", int'(ringing) * 10 + int'(mode), 0);

    // Snooze press coinciding with the final tick wins.
    set_time(7, 29, 0);
    step(1);
    set_time(7, 30, 0);
    step(1);
    set_time(7, 30, 1);
    for (int i = 0; i < RS - 1; i++) tick_pulse(4'b0);
    tick_pulse(4'b0010);
    chk("lit_press_wins", int'(snooze_act), 1);
    step(2);
    chk("lit_single_exit", int'(mode), 0);

    // Reset during time-minute edit: no load, settings lost.
    press(4'b0001);
    press(4'b0001);
    chk("lit_in_edit_tm", int'(mode), 2);
    rst_n = 1'b0;
    step(2);
    chk("lit_rst_no_load", int'(time_load), 0);
    chk("lit_rst_alarm", int'(alarm_hour) * 100 + int'(alarm_min), 600);
    chk("lit_rst_en", int'(alarm_en) * 10 + int'(snooze_act), 0);
    rst_n = 1'b1;
    step(3);
    chk("lit_after_rst_load", int'(time_load), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
